// File: rtl/xorshift_pkg.sv
// rtl/xorshift_pkg.sv - shared constants and state type for the xorshift32 generator/checker
// Contents: XS_W word width, XS_SH_A/B/C shift amounts, xs_state_e checker state.
package xorshift_pkg;

  localparam int XS_W    = 32;
  localparam int XS_SH_A = 13;
  localparam int XS_SH_B = 17;
  localparam int XS_SH_C = 5;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } xs_state_e;

endpackage

// File: rtl/xorshift_step.sv
// rtl/xorshift_step.sv - one combinational xorshift32 step (13/17/5)
// Ports:
//   x  in  XS_W : current value
//   y  out XS_W : next value in the sequence
module xorshift_step
  import xorshift_pkg::*;
(
  input  logic [XS_W-1:0] x,
  output logic [XS_W-1:0] y
);

  logic [XS_W-1:0] a;
  logic [XS_W-1:0] b;

  always_comb begin
    a = x ^ (x << XS_SH_A);
    b = a ^ (a >> XS_SH_B);
    y = b ^ (b << XS_SH_C);
  end

endmodule

// File: rtl/xorshift_checker.sv
// rtl/xorshift_checker.sv - self-synchronising xorshift32 stream checker with lock and error counters
// Optional build macro: XSCHK_STALL_EN (drops s_tready one cycle in every eight).
// Ports:
//   clk, arst          : clock, asynchronous active-high reset
//   clear              : synchronous clear of counters and state
//   s_tvalid/s_tready/s_tdata : incoming 32-bit word stream
//   locked             : checker synchronised to the sequence
//   err_count          : mismatches while locked, saturating
//   word_count         : accepted words, wrapping
module xorshift_checker
  import xorshift_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clear,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [XS_W-1:0]  s_tdata,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count
);

  localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);
  localparam logic [7:0]       LOSS_N  = 8'(LOSS_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  xs_state_e        state_q, state_n;
  logic [XS_W-1:0]  expected_q, expected_n;
  logic             have_seed_q, have_seed_n;
  logic [7:0]       run_q, run_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic [31:0]      wc_q, wc_n;
  logic             rdy_q;

  logic [XS_W-1:0]  step_data;
  logic [XS_W-1:0]  step_expected;
  logic [7:0]       run_inc;
  logic             accept;

  // Seeding/resync path follows the received word; the locked path free-runs
  // from the prediction so a corrupted word never derails the sequence.
  xorshift_step u_step_data (
    .x (s_tdata),
    .y (step_data)
  );

  xorshift_step u_step_expected (
    .x (expected_q),
    .y (step_expected)
  );

`ifdef XSCHK_STALL_EN
  logic [2:0] stall_cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= 3'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 3'd1;
    end
  end

  assign s_tready = rdy_q && (stall_cnt_q != 3'd7);
`else
  assign s_tready = rdy_q;
`endif

  assign accept     = s_tvalid && s_tready;
  assign run_inc    = run_q + 8'd1;
  assign locked     = (state_q == LOCKED);
  assign err_count  = err_q;
  assign word_count = wc_q;

  always_comb begin
    state_n     = state_q;
    expected_n  = expected_q;
    have_seed_n = have_seed_q;
    run_n       = run_q;
    err_n       = err_q;
    wc_n        = wc_q;

    if (clear) begin
      state_n     = SEARCH;
      have_seed_n = 1'b0;
      run_n       = 8'd0;
      err_n       = '0;
      wc_n        = 32'd0;
    end else if (accept) begin
      wc_n = wc_q + 32'd1;
      unique case (state_q)
        SEARCH: begin
          if (s_tdata == '0) begin
            // Zero is a fixed point of xorshift, never a usable seed.
            have_seed_n = 1'b0;
            run_n       = 8'd0;
          end else if (!have_seed_q) begin
            expected_n  = step_data;
            have_seed_n = 1'b1;
            run_n       = 8'd0;
          end else if (s_tdata == expected_q) begin
            expected_n = step_data;
            if (run_inc == LOCK_N) begin
              state_n = LOCKED;
              run_n   = 8'd0;
            end else begin
              run_n = run_inc;
            end
          end else begin
            expected_n = step_data;
            run_n      = 8'd0;
          end
        end
        LOCKED: begin
          expected_n = step_expected;
          if (s_tdata == expected_q) begin
            run_n = 8'd0;
          end else begin
            if (err_q != ERR_MAX) begin
              err_n = err_q + ERR_W'(1);
            end
            if (run_inc == LOSS_N) begin
              state_n     = SEARCH;
              have_seed_n = 1'b0;
              run_n       = 8'd0;
            end else begin
              run_n = run_inc;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= SEARCH;
      expected_q  <= '0;
      have_seed_q <= 1'b0;
      run_q       <= 8'd0;
      err_q       <= '0;
      wc_q        <= 32'd0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      expected_q  <= expected_n;
      have_seed_q <= have_seed_n;
      run_q       <= run_n;
      err_q       <= err_n;
      wc_q        <= wc_n;
      rdy_q       <= 1'b1;
    end
  end

endmodule

// File: doc/xorshift_checker.md
# xorshift_checker

AXI-Stream sink that verifies a stream of 32-bit xorshift32 words (shifts 13/17/5) produced by the team's `xorshift` generator. It self-synchronises to the incoming sequence without a shared seed, then counts mismatched words. It sits at the receiving end of the axirandom link, either in loopback benches or on-chip after a transport path, and exposes lock status and error and word counters to a register block.

## Interface
Parameters:
- `LOCK_COUNT`, 4: consecutive matches required to declare lock (1..255).
- `LOSS_COUNT`, 8: consecutive mismatches in LOCKED that drop lock (1..255).
- `ERR_W`, 16: width of the error counter.

Ports:
- `clk` input 1: clock; all logic on rising edge.
- `arst` input 1: reset, asynchronous and active-high.
- `clear` input 1: synchronous clear of counters and state, returning to SEARCH.
- `s_tvalid` input 1: stream word valid.
- `s_tready` output 1: checker ready.
- `s_tdata` input 32: stream word.
- `locked` output 1: checker synchronised.
- `err_count` output ERR_W: mismatched words while LOCKED, saturating.
- `word_count` output 32: accepted words since reset or clear, wrapping.

## Operation
- A word is accepted on any edge where `s_tvalid && s_tready`. Nothing happens on edges without an accept, except `clear`.
- Internal registers:
  - `expected` (32b): the next predicted word.
  - `have_seed` (1b).
  - `run` (8b): consecutive match or mismatch count.
  - `state`: SEARCH or LOCKED.
- `step(x)` computes one xorshift32 step:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
- SEARCH, on accept of word `w`:
  - `w == 0`: not a legal xorshift value. `have_seed` <= 0 and `run` <= 0.
  - `!have_seed`: `expected` <= step(w), `have_seed` <= 1, `run` <= 0.
  - `w == expected`: `run` <= `run`+1 and `expected` <= step(w). When `run`+1 == LOCK_COUNT, go to LOCKED and set `run` <= 0.
  - Otherwise (mismatch): reseed with `expected` <= step(w) and `run` <= 0.
- LOCKED, on accept of word `w`:
  - `expected` <= step(`expected`) unconditionally. It does not track the received word, so one corrupted word costs exactly one error.
  - On match, `run` <= 0.
  - On mismatch, `err_count` increments (saturating at all-ones) and `run` <= `run`+1. When `run`+1 == LOSS_COUNT, go to SEARCH with `have_seed` <= 0 and `run` <= 0.
- `word_count` increments on every accept in both states and wraps from 0xFFFFFFFF to 0.
- `clear` has priority over a same-edge accept; that word is discarded and not counted. `clear` zeroes the counters, `run`, `have_seed` and `locked`, and forces SEARCH.
- Without XSCHK_STALL_EN, `s_tready` is 1 at all times outside reset.

## Timing
- Reset values:
  - `s_tready`=0, `locked`=0, `err_count`=0, `word_count`=0.
  - State SEARCH, `have_seed`=0, `expected`=0.
- `s_tready` rises on the first edge after `arst` deasserts.
- All outputs are registered. Latency from an accept edge to a visible output change is 1 cycle.
- `locked` rises on the edge that accepts the LOCK_COUNT-th consecutive match. Minimum is LOCK_COUNT+1 accepted words after entering SEARCH.
- `locked` falls on the edge that accepts the LOSS_COUNT-th consecutive mismatch. That word is counted in `err_count`.
- If `arst` is asserted mid-stream, everything returns to reset values immediately. Resync then needs LOCK_COUNT+1 new words.
- A source holding `s_tvalid` while `s_tready` is low must keep `s_tdata` stable.

## Configuration
- `XSCHK_STALL_EN` defined:
  - A 3-bit free-running cycle counter (reset 0) drives `s_tready` low whenever the counter == 7, i.e. one cycle in every 8.
  - Purpose: exercise source backpressure.
  - The counter runs regardless of `clear`.
- `XSCHK_STALL_EN` undefined: no counter; `s_tready` behaves as in Operation.

## Structure
- Package `xorshift_pkg`:
  - Shift constants `XS_SH_A`=13, `XS_SH_B`=17, `XS_SH_C`=5.
  - `XS_W`=32.
  - State enum (SEARCH, LOCKED).
- Sub-module `xorshift_step`: purely combinational, one 32-bit input, one 32-bit output.
  - The checker instantiates it twice: once fed with `s_tdata` for seeding, once fed with `expected` for the LOCKED advance.
  - The generator can share it.

## Test plan
- Reset, then stream 1, 0x00042021, … (generator from seed 1, continuous valid) → `locked`=1 after the 5th accept; `err_count`=0; `word_count`=5 at that point.
- After lock, flip bit 0 of one word → `err_count`=1; `locked` stays 1; the following words match again with no further errors.
- After lock, send 8 consecutive 0xDEADBEEF → `err_count`=8 and `locked`=0 on the 8th; then a fresh generator sequence relocks after 5 words.
- In SEARCH, send 0, then a valid sequence → the 0 is not used as a seed; lock after 5 further words; `word_count` includes the 0.
- Assert `clear` on the same edge as an accepted word while locked → the counters read 0 and `locked`=0 next cycle, and that word is not counted.
- With `XSCHK_STALL_EN` defined → `s_tready` is low exactly every 8th cycle, and a backpressure-respecting generator still locks with `err_count`=0.
